// File: rtl/dualport_pkg.sv
// Shared types and helpers for the dual-port RAM: read-during-write policy,
// init/ready state encoding and the address-width rule.
package dualport_pkg;

   typedef enum logic {WRITE_FIRST, READ_FIRST} rdw_mode_e;

   typedef enum logic {INIT, READY} ram_state_e;

   // Address width never drops below one bit, even for a two-word memory.
   function automatic int addr_w(input int depth);
      return ($clog2(depth) > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dualport_ram_p_rdpipe.sv
// READ_LAT-deep output register chain for read responses. Data is held in
// every stage while it is empty, so the last stage keeps its last valid word.
module dualport_ram_p_rdpipe #(
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_err,
   input  logic              in_coll,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_err,
   output logic              out_coll
);

   logic [DATA_W-1:0] data_q [READ_LAT];
   logic [DATA_W-1:0] data_d [READ_LAT];
   logic [DATA_W-1:0] s_data [READ_LAT];
   logic [READ_LAT-1:0] valid_q, valid_d, err_q, err_d, coll_q, coll_d;
   logic [READ_LAT-1:0] s_valid, s_err, s_coll;

   for (genvar g = 0; g < READ_LAT; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign s_data[g]  = in_data;
         assign s_valid[g] = in_valid;
         assign s_err[g]   = in_err;
         assign s_coll[g]  = in_coll;
      end else begin : g_next
         assign s_data[g]  = data_q[g-1];
         assign s_valid[g] = valid_q[g-1];
         assign s_err[g]   = err_q[g-1];
         assign s_coll[g]  = coll_q[g-1];
      end
   end

   // Flags are forced low on bubbles; data only moves with a valid entry.
   always_comb begin
      valid_d = s_valid;
      err_d   = s_valid & s_err;
      coll_d  = s_valid & s_coll;
      for (int i = 0; i < READ_LAT; i++) begin
         data_d[i] = s_valid[i] ? s_data[i] : data_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '{default: '0};
         valid_q <= '0;
         err_q   <= '0;
         coll_q  <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         coll_q  <= coll_d;
      end
   end

   assign out_data  = data_q[READ_LAT-1];
   assign out_valid = valid_q[READ_LAT-1];
   assign out_err   = err_q[READ_LAT-1];
   assign out_coll  = coll_q[READ_LAT-1];

endmodule

// File: rtl/dualport_ram_p.sv
// One-write/one-read RAM with byte enables, selectable read-during-write
// policy, out-of-range detection and a zeroing sweep after every reset.
module dualport_ram_p
   import dualport_pkg::*;
#(
   parameter int        DATA_W   = 32,
   parameter int        DEPTH    = 16,
   parameter int        READ_LAT = 1,
   parameter rdw_mode_e RDW_MODE = WRITE_FIRST,
   localparam int       AW       = addr_w(DEPTH),
   localparam int       BE_W     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   input  logic              wr,
   input  logic              rd,
   input  logic [AW-1:0]     w_addr,
   input  logic [AW-1:0]     r_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [BE_W-1:0]   w_be,
   output logic [DATA_W-1:0] r_data,
   output logic              r_valid,
   output logic              r_err,
   output logic              collision,
   output logic              ready
);

   ram_state_e        state_q, state_d;
   logic [AW-1:0]     init_addr_q, init_addr_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic              wr_acc, rd_acc, init_we, coll;
   logic              w_hit, r_hit;
   logic [DATA_W-1:0] w_old, r_old, w_merged, rd_word;

   // Reset wins over any request, including one arriving in the reset cycle.
   assign wr_acc  = ready_q & enb & wr & ~rst;
   assign rd_acc  = ready_q & enb & rd & ~rst;
   assign init_we = (state_q == INIT) & ~rst;

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      if (state_q == INIT) begin
         init_addr_d = init_addr_q + AW'(1);
         if (init_addr_q == AW'(DEPTH - 1)) begin
            state_d = READY;
         end
      end
      ready_d = (state_d == READY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         init_addr_q <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         ready_q     <= ready_d;
      end
   end

   // Address decode by compare keeps indexing inside the array when DEPTH < 2**AW.
   always_comb begin
      w_hit = 1'b0;
      r_hit = 1'b0;
      w_old = '0;
      r_old = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_addr == AW'(i)) begin
            w_hit = 1'b1;
            w_old = mem_q[i];
         end
         if (r_addr == AW'(i)) begin
            r_hit = 1'b1;
            r_old = mem_q[i];
         end
      end
      w_merged = w_old;
      for (int b = 0; b < BE_W; b++) begin
         if (w_be[b]) begin
            w_merged[8*b +: 8] = w_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (init_we && (init_addr_q == AW'(i))) begin
            mem_d[i] = '0;
         end
         if (wr_acc && (w_addr == AW'(i))) begin
            mem_d[i] = w_merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign coll = rd_acc & wr_acc & w_hit & (w_addr == r_addr);

   always_comb begin
      rd_word = '0;
      if (r_hit) begin
         rd_word = (coll && (RDW_MODE == WRITE_FIRST)) ? w_merged : r_old;
      end
   end

   dualport_ram_p_rdpipe #(
      .DATA_W   (DATA_W),
      .READ_LAT (READ_LAT)
   ) u_rdpipe (
      .clk       (clk),
      .rst       (rst),
      .in_data   (rd_word),
      .in_valid  (rd_acc),
      .in_err    (~r_hit),
      .in_coll   (coll),
      .out_data  (r_data),
      .out_valid (r_valid),
      .out_err   (r_err),
      .out_coll  (collision)
   );

   assign ready = ready_q;

endmodule
